// File: rtl/apb_slave_bridge.sv
// -----------------------------------------------------------------------------
// apb_slave_bridge
//
// APB completer (PSTRB-capable) that hands each host transfer to an internal
// configuration-space agent over a request/grant/acknowledge port.
//
// A transfer is captured in the ACCESS cycle:
//   - Without an error, the captured transfer requests the config-space port.
//     It waits for grant and then for the acknowledge pulse.
//   - With an error, the config-space request is skipped entirely.
// The APB side then sees a single-cycle PREADY, together with PSLVERR.
// Every output is a register.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   PSEL, PENABLE         APB select / ACCESS-phase enable
//   PWRITE, PADDR         APB direction and address
//   PWDATA, PSTRB         APB write data and byte strobes
//   Addr_ER, Parity_ER    error flags, sampled with the ACCESS cycle
//   APB_Grant             config-space port granted
//   ConfigSp_ACKAPB       config-space done pulse
//   ConfigSp_DATA         config-space read data, valid with the ack
//   APB_Request           config-space port request
//   APB_OADDR, APB_ODATA  captured address / write data
//   APB_OSTRB, APB_OWRITE captured strobes (zero on reads) / direction
//   PREADY                transfer complete, one-cycle pulse
//   PRDATA                last successful read data
//   PSLVERR               {Parity_ER, Addr_ER} while PREADY is high
// -----------------------------------------------------------------------------
module apb_slave_bridge #(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [ADDR_WD-1:0] PADDR,
    input  logic [DATA_WD-1:0] PWDATA,
    input  logic [3:0]         PSTRB,
    input  logic               Addr_ER,
    input  logic               Parity_ER,
    input  logic               APB_Grant,
    input  logic               ConfigSp_ACKAPB,
    input  logic [DATA_WD-1:0] ConfigSp_DATA,
    output logic               APB_Request,
    output logic [ADDR_WD-1:0] APB_OADDR,
    output logic [DATA_WD-1:0] APB_ODATA,
    output logic [3:0]         APB_OSTRB,
    output logic               APB_OWRITE,
    output logic               PREADY,
    output logic [DATA_WD-1:0] PRDATA,
    output logic [1:0]         PSLVERR
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        REQ   = 3'd2,
        XFER  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;

    logic               req_q,    req_nxt;
    logic [ADDR_WD-1:0] oaddr_q,  oaddr_nxt;
    logic [DATA_WD-1:0] odata_q,  odata_nxt;
    logic [3:0]         ostrb_q,  ostrb_nxt;
    logic               owrite_q, owrite_nxt;
    logic               ready_q,  ready_nxt;
    logic [DATA_WD-1:0] rdata_q,  rdata_nxt;
    logic [1:0]         slverr_q, slverr_nxt;
    // Error flags captured with the transfer.
    // They are reported only in the PREADY cycle.
    logic [1:0]         err_q,    err_nxt;

    // State register and registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            oaddr_q  <= '0;
            odata_q  <= '0;
            ostrb_q  <= '0;
            owrite_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= '0;
            err_q    <= '0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            oaddr_q  <= oaddr_nxt;
            odata_q  <= odata_nxt;
            ostrb_q  <= ostrb_nxt;
            owrite_q <= owrite_nxt;
            ready_q  <= ready_nxt;
            rdata_q  <= rdata_nxt;
            slverr_q <= slverr_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        req_nxt    = req_q;
        oaddr_nxt  = oaddr_q;
        odata_nxt  = odata_q;
        ostrb_nxt  = ostrb_q;
        owrite_nxt = owrite_q;
        rdata_nxt  = rdata_q;
        err_nxt    = err_q;
        // PREADY/PSLVERR are pulses: they are low unless leaving DONE.
        ready_nxt  = 1'b0;
        slverr_nxt = 2'b00;

        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = SETUP;
                end
            end

            SETUP: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    oaddr_nxt  = PADDR;
                    odata_nxt  = PWDATA;
                    ostrb_nxt  = PWRITE ? PSTRB : 4'b0000;
                    owrite_nxt = PWRITE;
                    err_nxt    = {Parity_ER, Addr_ER};
                    if (Parity_ER || Addr_ER) begin
                        // Erroneous transfers never touch config space.
                        state_nxt = DONE;
                    end else begin
                        state_nxt = REQ;
                        req_nxt   = 1'b1;
                    end
                end
            end

            REQ: begin
                // An ack arriving together with the grant is not accepted.
                // The grant must first move the FSM into XFER.
                if (APB_Grant) begin
                    state_nxt = XFER;
                end
            end

            XFER: begin
                // Grant may drop here.
                // Completion is decided only by the ack.
                if (ConfigSp_ACKAPB) begin
                    if (!owrite_q) begin
                        rdata_nxt = ConfigSp_DATA;
                    end
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                ready_nxt  = 1'b1;
                slverr_nxt = err_q;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign APB_Request = req_q;
    assign APB_OADDR   = oaddr_q;
    assign APB_ODATA   = odata_q;
    assign APB_OSTRB   = ostrb_q;
    assign APB_OWRITE  = owrite_q;
    assign PREADY      = ready_q;
    assign PRDATA      = rdata_q;
    assign PSLVERR     = slverr_q;

endmodule

// File: tb/tb_apb_slave_bridge.sv
module tb_apb_slave_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        Addr_ER, Parity_ER, APB_Grant, ConfigSp_ACKAPB;
    logic [31:0] ConfigSp_DATA;
    logic        APB_Request;
    logic [15:0] APB_OADDR;
    logic [31:0] APB_ODATA;
    logic [3:0]  APB_OSTRB;
    logic        APB_OWRITE, PREADY;
    logic [31:0] PRDATA;
    logic [1:0]  PSLVERR;

    apb_slave_bridge #(.DATA_WD(32), .ADDR_WD(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .Addr_ER(Addr_ER), .Parity_ER(Parity_ER), .APB_Grant(APB_Grant),
        .ConfigSp_ACKAPB(ConfigSp_ACKAPB), .ConfigSp_DATA(ConfigSp_DATA),
        .APB_Request(APB_Request), .APB_OADDR(APB_OADDR), .APB_ODATA(APB_ODATA),
        .APB_OSTRB(APB_OSTRB), .APB_OWRITE(APB_OWRITE), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] prdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp   = 0;
    int          n_mis   = 0;
    int          n_ready = 0;
    logic        mon_en  = 1'b0;
    logic [31:0] exp_prdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Completion monitor: every PREADY pulse consumes one expectation.
    always @(negedge PCLK) begin
        if (mon_en) begin
            if (PREADY) begin
                n_ready++;
                if (exp_q.size() == 0) begin
                    chk("unexp_pready", PREADY, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("prdata", PRDATA, e.prdata);
                    chk("pslverr", PSLVERR, e.err);
                end
            end else begin
                chk("pslverr_idle", PSLVERR, 2'b00);
            end
        end
    end

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic aer, input logic per,
                        input int gdly, input int adly, input logic [31:0] rdata,
                        input logic drop, input logic withdraw, input logic ackgrant);
        logic [1:0] err;
        exp_t       e;
        int         rdy0;
        err = {per, aer};
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        tick();
        PENABLE = 1'b1; Addr_ER = aer; Parity_ER = per;
        if (err == 2'b00 && !wr) exp_prdata = rdata;
        e.prdata = exp_prdata;
        e.err    = err;
        exp_q.push_back(e);
        rdy0 = n_ready;
        tick();
        Addr_ER = 1'b0; Parity_ER = 1'b0;
        chk("oaddr", APB_OADDR, addr);
        chk("odata", APB_ODATA, wdata);
        chk("ostrb", APB_OSTRB, wr ? strb : 4'b0000);
        chk("owrite", APB_OWRITE, wr);
        chk("req_on", APB_Request, err == 2'b00);
        chk("rdy_early0", PREADY, 1'b0);
        if (drop) begin
            PSEL = 1'b0; PENABLE = 1'b0; PADDR = 16'hFFFF; PWDATA = 32'hFFFF_FFFF;
        end
        if (err != 2'b00) begin
            tick();
            chk("req_err", APB_Request, 1'b0);
        end else begin
            for (int i = 0; i < gdly; i++) begin
                tick();
                chk("req_wait", APB_Request, 1'b1);
            end
            APB_Grant = 1'b1;
            if (ackgrant) begin
                ConfigSp_ACKAPB = 1'b1;
                ConfigSp_DATA   = ~rdata;
            end
            tick();
            ConfigSp_ACKAPB = 1'b0;
            if (withdraw) APB_Grant = 1'b0;
            for (int i = 0; i < adly - 1; i++) begin
                tick();
                chk("req_hold", APB_Request, 1'b1);
                chk("rdy_wait", PREADY, 1'b0);
            end
            chk("oaddr_hold", APB_OADDR, addr);
            chk("odata_hold", APB_ODATA, wdata);
            ConfigSp_ACKAPB = 1'b1;
            ConfigSp_DATA   = rdata;
            tick();
            ConfigSp_ACKAPB = 1'b0;
            APB_Grant       = 1'b0;
            ConfigSp_DATA   = $urandom;
            chk("req_off", APB_Request, 1'b0);
            chk("rdy_early", PREADY, 1'b0);
            tick();
        end
        chk("rdy_pulse", PREADY, 1'b1);
        tick();
        chk("rdy_low", PREADY, 1'b0);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("rdy_count", n_ready - rdy0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        PSTRB = '0; Addr_ER = 1'b0; Parity_ER = 1'b0; APB_Grant = 1'b0;
        ConfigSp_ACKAPB = 1'b0; ConfigSp_DATA = '0;
        exp_prdata = '0;
        tick();
        PRESET = 1'b0;
        // 1. reset values
        chk("rst_req", APB_Request, 1'b0);
        chk("rst_oaddr", APB_OADDR, 16'h0);
        chk("rst_odata", APB_ODATA, 32'h0);
        chk("rst_ostrb", APB_OSTRB, 4'h0);
        chk("rst_owrite", APB_OWRITE, 1'b0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", PSLVERR, 2'b00);
        mon_en = 1'b1;
        tick();

        // 2. write, no error: grant 3 cycles later, ack 2 after grant
        xfer(1'b1, 16'd12, 32'd152, 4'b1111, 1'b0, 1'b0, 3, 2, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
        chk("wr_prdata_kept", PRDATA, 32'd0);
        // 3. read of 150
        xfer(1'b0, 16'd34, 32'd0, 4'b0000, 1'b0, 1'b0, 1, 1, 32'd150, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("rd_prdata_hold", PRDATA, 32'd150);
        // read with strobes driven: captured strobes must be zero
        xfer(1'b0, 16'h0ABC, 32'h1234_5678, 4'b1010, 1'b0, 1'b0, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        // 4. address error (read, so PRDATA must stay)
        xfer(1'b0, 16'd7, 32'h55, 4'b0011, 1'b1, 1'b0, 0, 0, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
        // parity error and both errors on writes
        xfer(1'b1, 16'd8, 32'h66, 4'b0001, 1'b0, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 16'd9, 32'h77, 4'b1000, 1'b1, 1'b1, 0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        // 5. host drops PSEL, grant after 10 cycles and withdrawn before ack
        xfer(1'b1, 16'h0100, 32'hA5A5_5A5A, 4'b0110, 1'b0, 1'b0, 10, 4, 32'h0, 1'b1, 1'b1, 1'b0);
        // ack coincident with grant in REQ is not accepted
        xfer(1'b0, 16'h0200, 32'h0, 4'b0000, 1'b0, 1'b0, 2, 3, 32'h1357_9BDF, 1'b0, 1'b0, 1'b1);

        // 6. reset during XFER
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'd9; PWDATA = 32'd77; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        tick();
        APB_Grant = 1'b1;
        tick();
        APB_Grant = 1'b0;
        chk("xfer_req", APB_Request, 1'b1);
        rdy0 = n_ready;
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        exp_prdata = '0;
        chk("mid_rst_req", APB_Request, 1'b0);
        chk("mid_rst_oaddr", APB_OADDR, 16'h0);
        chk("mid_rst_odata", APB_ODATA, 32'h0);
        chk("mid_rst_ostrb", APB_OSTRB, 4'h0);
        chk("mid_rst_owrite", APB_OWRITE, 1'b0);
        chk("mid_rst_prdata", PRDATA, 32'h0);
        chk("mid_rst_pready", PREADY, 1'b0);
        // stray ack in IDLE must be ignored
        ConfigSp_ACKAPB = 1'b1; ConfigSp_DATA = 32'hFACE;
        tick();
        ConfigSp_ACKAPB = 1'b0;
        repeat (3) tick();
        chk("no_rdy_after_rst", n_ready - rdy0, 0);
        chk("stray_ack_req", APB_Request, 1'b0);
        xfer(1'b1, 16'd1, 32'd5, 4'b1111, 1'b0, 1'b0, 1, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_slave_bridge.md
Name: apb_slave_bridge

Overview:
APB (v2-style, PSTRB-capable) completer that bridges host APB transfers to an internal configuration-space agent. It captures the transfer during the ACCESS phase and requests the config-space port (request/grant). It presents address, data and strobes on that port, waits for the config-space acknowledge, then completes the APB transfer with PREADY, plus PRDATA for reads and PSLVERR on errors. Single clock domain.

Parameters:
DATA_WD, 32, width of PWDATA/PRDATA/APB_ODATA/ConfigSp_DATA
ADDR_WD, 16, width of PADDR/APB_OADDR

Ports:
PCLK  in  1  sole clock; all logic on rising edge
PRESET  in  1  synchronous, active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable (ACCESS phase)
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_WD  APB address
PWDATA  in  DATA_WD  APB write data
PSTRB  in  4  APB byte strobes
Addr_ER  in  1  address-error flag from decoder
Parity_ER  in  1  parity-error flag
APB_Grant  in  1  config-space port granted to this slave
ConfigSp_ACKAPB  in  1  config-space transaction done (1-cycle pulse)
ConfigSp_DATA  in  DATA_WD  read data from config space, valid with ack
APB_Request  out  1  request for config-space port
APB_OADDR  out  ADDR_WD  captured address to config space
APB_ODATA  out  DATA_WD  captured write data to config space
APB_OSTRB  out  4  captured strobes (0 on reads)
APB_OWRITE  out  1  captured direction to config space
PREADY  out  1  transfer complete, 1-cycle pulse
PRDATA  out  DATA_WD  read data
PSLVERR  out  2  {Parity_ER, Addr_ER} error status

Behaviour:
- Reset (PRESET=1 at a PCLK edge): FSM->IDLE; all outputs 0, including PRDATA. Reset mid-transfer aborts it; no PREADY is issued.
- FSM states: IDLE, SETUP, REQ, XFER, DONE. All outputs are registered.
- IDLE: PSEL=1 & PENABLE=0 -> SETUP.
- SETUP: PSEL=1 & PENABLE=1 -> capture PADDR, PWDATA, PWRITE and PSTRB (forced to 0 if PWRITE=0) into APB_O* outputs.
  - Capture Addr_ER/Parity_ER in the same cycle.
  - No error -> REQ. Either error -> DONE, with no config-space request.
- SETUP: PSEL=0 -> IDLE. PSEL=1 & PENABLE=0 -> stay.
- REQ: APB_Request=1. APB_Grant=1 -> XFER.
- XFER: APB_Request stays 1, APB_O* held stable. On ConfigSp_ACKAPB=1:
  - if read, PRDATA<=ConfigSp_DATA;
  - APB_Request<=0; -> DONE.
  - Grant dropping before ack is ignored; keep waiting.
- DONE: PREADY=1 for exactly one cycle. PSLVERR = captured {Parity_ER, Addr_ER} during this cycle, 0 otherwise. -> IDLE.
- Once captured, PSEL/PENABLE/PADDR/PWDATA changes are ignored until return to IDLE; the host may drop PSEL before PREADY.
- Latency from the ACCESS cycle edge:
  - REQ at +1.
  - PREADY one cycle after the ack-sampling edge.
  - Error path: PREADY at +2.
- PRDATA holds its last read value until the next successful read or reset. Writes and error transfers leave it unchanged.
- APB_O* retain the last captured values in IDLE.
- Ack outside XFER is ignored; an ack coincident with grant in REQ is not accepted (the grant moves the FSM to XFER first).
- No outstanding transactions; a new SETUP is accepted only in IDLE.

Test Plan:
1. Reset: PRESET=1 for 1 cycle -> all outputs 0, FSM IDLE.
2. Write, no errors:
   - Stimulus: SETUP then ACCESS, PWRITE=1, PWDATA=152, PADDR=12, PSTRB=4'b1111; grant 3 cycles later; ack 2 cycles after grant.
   - Response: APB_Request=1 from ACCESS+1 until ack; APB_ODATA=152, APB_OADDR=12, APB_OSTRB=1111, APB_OWRITE=1; PREADY one-cycle pulse after ack; PSLVERR=0; PRDATA unchanged (0).
3. Read:
   - Stimulus: PWRITE=0, PADDR=34, PSTRB=0; grant; ack with ConfigSp_DATA=150.
   - Response: APB_OSTRB=0, APB_OWRITE=0; PREADY pulse; PRDATA=150 and holding afterwards.
4. Address error: Addr_ER=1 during ACCESS, PADDR=7 -> APB_Request never asserts; PREADY at ACCESS+2; PSLVERR=2'b01 during PREADY only.
5. Host drops PSEL during REQ; grant is delayed 10 cycles and withdrawn before ack -> transfer still completes on ack; single PREADY pulse.
6. PRESET asserted during XFER -> immediate IDLE, outputs 0, no PREADY; a following write (PWDATA=5, PADDR=1) completes normally.
